// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-side logic: FSM encoding, BCD limit
// and the default tone lengths in video frames.
package pong_pkg;

  localparam logic [7:0] BCD_MAX = 8'h99;

  localparam int POINT_FRAMES_DEF = 8;
  localparam int LOSE_FRAMES_DEF  = 30;
  localparam int LIVES_DEF        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POINT = 2'd1,
    ST_LOSE  = 2'd2
  } pong_state_e;

endpackage

// File: rtl/bcd_inc_sat.sv
// Two-digit BCD incrementer that saturates at 99; passes the value through
// unchanged when en is low.
module bcd_inc_sat
  import pong_pkg::*;
(
  input  logic       en,
  input  logic [7:0] value,
  output logic [7:0] result
);

  logic [3:0] tens;
  logic [3:0] units;

  assign tens  = value[7:4];
  assign units = value[3:0];

  always_comb begin
    result = value;
    if (en && (value != BCD_MAX)) begin
      if (units == 4'd9) begin
        result = {tens + 4'd1, 4'd0};
      end else begin
        result = {tens, units + 4'd1};
      end
    end
  end

endmodule

// File: rtl/pong_sound_events.sv
// Turns ball hit/miss pulses into frame-timed point/lose tone requests and
// keeps score, lives and the sticky game-over flag.
module pong_sound_events
  import pong_pkg::*;
#(
  parameter int POINT_FRAMES = POINT_FRAMES_DEF,
  parameter int LOSE_FRAMES  = LOSE_FRAMES_DEF,
  parameter int LIVES        = LIVES_DEF
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic       ball_hit,
  input  logic       ball_miss,
  output logic       point,
  output logic       lose,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] POINT = ST_POINT;
  localparam logic [1:0] LOSE  = ST_LOSE;

  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [7:0] LOSE_LAST  = 8'(LOSE_FRAMES - 1);

  logic [1:0] state;
  logic [1:0] state_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic [7:0] frame_last;
  logic [7:0] score_n;
  logic       hit_ok;
  logic       miss_ok;

  assign hit_ok    = ball_hit & ~game_over;
  assign miss_ok   = ball_miss & ~game_over;
  assign fsm_state = state;

  bcd_inc_sat u_score_inc (
    .en     (hit_ok),
    .value  (score),
    .result (score_n)
  );

  // Any accepted event blocks frame ageing in that cycle; a hit never
  // preempts an active lose tone.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    frame_last = (state == LOSE) ? LOSE_LAST : POINT_LAST;
    if (miss_ok) begin
      state_n = LOSE;
      cnt_n   = 8'd0;
    end else if (hit_ok) begin
      if (state != LOSE) begin
        state_n = POINT;
        cnt_n   = 8'd0;
      end
    end else if (frame_tick && (state != IDLE)) begin
      if (cnt == frame_last) begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end else begin
        cnt_n = cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset || restart) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      point     <= 1'b0;
      lose      <= 1'b0;
      score     <= 8'h00;
      lives     <= 2'(LIVES);
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      point <= (state_n == POINT);
      lose  <= (state_n == LOSE);
      score <= score_n;
      if (miss_ok) begin
        lives <= lives - 2'd1;
        if (lives == 2'd1) begin
          game_over <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_sound_events.sv
// Bench for pong_sound_events: a behavioural model predicts every cycle's
// outputs into a queue, which is popped and compared after each clock edge.
module tb_pong_sound_events;

  localparam int POINT_FRAMES = 8;
  localparam int LOSE_FRAMES  = 30;
  localparam int LIVES        = 3;
  localparam int TICK_PERIOD  = 3;

  logic       clk25;
  logic       reset;
  logic       frame_tick;
  logic       restart;
  logic       ball_hit;
  logic       ball_miss;
  logic       point;
  logic       lose;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic [1:0] fsm_state;

  pong_sound_events #(
    .POINT_FRAMES (POINT_FRAMES),
    .LOSE_FRAMES  (LOSE_FRAMES),
    .LIVES        (LIVES)
  ) dut (
    .clk25      (clk25),
    .reset      (reset),
    .frame_tick (frame_tick),
    .restart    (restart),
    .ball_hit   (ball_hit),
    .ball_miss  (ball_miss),
    .point      (point),
    .lose       (lose),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  // reference model: 0 idle, 1 point, 2 lose; score kept as decimal
  int m_state;
  int m_cnt;
  int m_score;
  int m_lives;
  bit m_go;
  int cyc;
  int n_checks;
  int n_fail;

  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit h, input bit m, input bit rst, input bit tick);
    bit h_ok;
    bit m_ok;
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_score = 0;
      m_lives = LIVES;
      m_go    = 1'b0;
    end else begin
      h_ok = h && !m_go;
      m_ok = m && !m_go;
      if (h_ok && m_score < 99) m_score++;
      if (m_ok) begin
        m_lives--;
        if (m_lives == 0) m_go = 1'b1;
        m_state = 2;
        m_cnt   = 0;
      end else if (h_ok) begin
        if (m_state != 2) begin
          m_state = 1;
          m_cnt   = 0;
        end
      end else if (tick && m_state != 0) begin
        m_cnt++;
        if (m_cnt == ((m_state == 1) ? POINT_FRAMES : LOSE_FRAMES)) begin
          m_state = 0;
          m_cnt   = 0;
        end
      end
    end
  endtask

  function automatic logic [14:0] model_word();
    logic [7:0] bcd;
    bcd = 8'(((m_score / 10) << 4) | (m_score % 10));
    return {2'(m_state), m_state == 1, m_state == 2, bcd, 2'(m_lives), m_go};
  endfunction

  function automatic bit tick_next();
    return (cyc % TICK_PERIOD) == (TICK_PERIOD - 1);
  endfunction

  // driver: one clock cycle of stimulus, then scoreboard compare
  task automatic step(input bit h, input bit m, input bit rs, input bit rst);
    logic [14:0] got;
    logic [14:0] exp;
    bit tick;
    tick       = tick_next();
    ball_hit   = h;
    ball_miss  = m;
    restart    = rs;
    reset      = rst;
    frame_tick = tick;
    model_update(h, m, rs | rst, tick);
    exp_q.push_back(model_word());
    @(posedge clk25);
    #1;
    cyc++;
    ball_hit   = 1'b0;
    ball_miss  = 1'b0;
    restart    = 1'b0;
    reset      = 1'b0;
    frame_tick = 1'b0;
    got = {fsm_state, point, lose, score, lives, game_over};
    exp = exp_q.pop_front();
    check($sformatf("cyc%0d{st,pt,lo,sc,lv,go}", cyc), 32'(got), 32'(exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int gap;
    bit found;
    reset      = 1'b1;
    restart    = 1'b0;
    frame_tick = 1'b0;
    ball_hit   = 1'b0;
    ball_miss  = 1'b0;
    cyc        = 0;
    n_checks   = 0;
    n_fail     = 0;
    m_state    = 0;
    m_cnt      = 0;
    m_score    = 0;
    m_lives    = LIVES;
    m_go       = 1'b0;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_lives", 32'(lives), 32'd3);
    check("reset_score", 32'(score), 32'h00);

    // single hit: point for 8 ticks, score 01
    idle(7);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hit_point_rise", 32'(point), 32'd1);
    idle(POINT_FRAMES * TICK_PERIOD + 6);
    check("hit_score", 32'(score), 32'h01);

    // hit, miss two frames later: lose preempts point
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2 * TICK_PERIOD);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("miss_lose_rise", 32'({point, lose}), 32'b01);
    idle(LOSE_FRAMES * TICK_PERIOD + 6);
    check("miss_lives", 32'(lives), 32'd2);

    // simultaneous hit and miss from idle
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("both_score", 32'(score), 32'h01);
    idle(LOSE_FRAMES * TICK_PERIOD + 6);

    // score carry and saturation
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 101; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 10) check("score_carry", 32'(score), 32'h10);
      gap = $urandom_range(0, 2);
      idle(gap);
    end
    check("score_sat", 32'(score), 32'h99);
    idle(POINT_FRAMES * TICK_PERIOD + 6);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_point", 32'({point, score}), 32'h199);

    // hit on the final frame tick retriggers point
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_state == 1 && m_cnt == POINT_FRAMES - 1 && tick_next()) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("align_last_tick", 32'(found), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("retrig_point", 32'(point), 32'd1);
    idle(POINT_FRAMES * TICK_PERIOD + 6);

    // three misses to game over; later hit ignored
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (k < 2) idle(LOSE_FRAMES * TICK_PERIOD + 4);
    end
    check("game_over", 32'({lives, game_over}), 32'b001);
    idle(10);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("go_hit_ignored", 32'(score), 32'h00);
    idle(LOSE_FRAMES * TICK_PERIOD + 6);
    check("go_tone_done", 32'(lose), 32'd0);

    // restart mid-lose
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_clear", 32'({lose, score, lives, game_over}), {19'd0, 1'b0, 8'h00, 2'd3, 1'b0});
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
